// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the data width, the funct3 access-size codes, the FSM state
// encoding and small decode helpers used by lsu and lsu_format.
package lsu_pkg;

  localparam int DATAWIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Any code outside the five listed ones behaves as a word access.
  // Store codes 100/101 land on B/H, so funct3[2] never matters for stores.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3_size(f3))
      SZ_H:    mis = a[0];
      SZ_W:    mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_format.sv
// Combinational lane formatting for the load/store unit.
// Ports:
//   addr_lo_i  byte offset within the word
//   funct3_i   access size / signedness code
//   wdata_i    store data as presented by the core (rs2)
//   rdata_i    read word returned by memory
//   be_o       byte enables for the access
//   wdata_o    store data replicated into every candidate lane
//   load_o     selected and sign/zero-extended load result
module lsu_format
  import lsu_pkg::*;
(
  input  logic [1:0]           addr_lo_i,
  input  logic [2:0]           funct3_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  input  logic [DATAWIDTH-1:0] rdata_i,
  output logic [3:0]           be_o,
  output logic [DATAWIDTH-1:0] wdata_o,
  output logic [DATAWIDTH-1:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    // Unsigned variants carry funct3[2]=1; W ignores this entirely.
    sext     = ~funct3_i[2];
    be_o     = 4'b1111;
    wdata_o  = wdata_i;
    load_o   = rdata_i;
    case (f3_size(funct3_i))
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        load_o  = {{24{byte_sel[7] & sext}}, byte_sel};
      end
      SZ_H: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        load_o  = {{16{half_sel[15] & sext}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access from the execute stage, issues a
// single held memory request, and returns a one-cycle completion pulse.
// Ports:
//   clk, rst                    clock, async active-high reset
//   lsu_valid/we/funct3/addr/wdata   access from execute stage
//   lsu_stall                   hold pipeline while access is outstanding
//   lsu_done/rdata/misalign     completion pulse, load result, misalign flag
//   mem_req/we/addr/be/wdata    memory request (word address)
//   mem_ack/rdata               memory completion and read data
module lsu
  import lsu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_valid,
  input  logic                 lsu_we,
  input  logic [2:0]           lsu_funct3,
  input  logic [DATAWIDTH-1:0] lsu_addr,
  input  logic [DATAWIDTH-1:0] lsu_wdata,
  output logic                 lsu_stall,
  output logic                 lsu_done,
  output logic [DATAWIDTH-1:0] lsu_rdata,
  output logic                 lsu_misalign,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATAWIDTH-1:0] mem_rdata
);

  lsu_state_e           state_q;
  logic [DATAWIDTH-1:0] addr_q;
  logic [2:0]           funct3_q;
  logic                 we_q;
  logic [DATAWIDTH-1:0] wdata_q;
  logic                 misalign_q;
  logic [DATAWIDTH-1:0] rdata_q;

  logic [3:0]           fmt_be;
  logic [DATAWIDTH-1:0] fmt_wdata;
  logic [DATAWIDTH-1:0] fmt_load;

  // Formatting works only from latched fields, so input changes after
  // acceptance cannot disturb the outstanding request.
  lsu_format u_format (
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_o      (fmt_be),
    .wdata_o   (fmt_wdata),
    .load_o    (fmt_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lsu_valid) begin
            rdata_q <= '0;
            if (is_misaligned(lsu_funct3, lsu_addr[1:0])) begin
              misalign_q <= 1'b1;
              state_q    <= ST_RESP;
            end else begin
              misalign_q <= 1'b0;
              addr_q     <= lsu_addr;
              funct3_q   <= lsu_funct3;
              we_q       <= lsu_we;
              wdata_q    <= lsu_wdata;
              state_q    <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            rdata_q <= we_q ? '0 : fmt_load;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registers so reset removes the request
  // without waiting for a clock edge.
  assign mem_req      = (state_q == ST_BUSY);
  assign mem_we       = mem_req & we_q;
  assign mem_be       = mem_req ? fmt_be : 4'b0000;
  assign mem_addr     = {addr_q[DATAWIDTH-1:2], 2'b00};
  assign mem_wdata    = fmt_wdata;
  assign lsu_done     = (state_q == ST_RESP);
  assign lsu_misalign = lsu_done & misalign_q;
  assign lsu_rdata    = rdata_q;
  assign lsu_stall    = ((state_q == ST_IDLE) & lsu_valid) | mem_req;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_stall, lsu_done, lsu_misalign;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .lsu_valid    (lsu_valid),
    .lsu_we       (lsu_we),
    .lsu_funct3   (lsu_funct3),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_stall    (lsu_stall),
    .lsu_done     (lsu_done),
    .lsu_rdata    (lsu_rdata),
    .lsu_misalign (lsu_misalign),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  delay;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        mis;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    lsu_valid  = 1'b1;
    lsu_we     = v.we;
    lsu_funct3 = v.f3;
    lsu_addr   = v.addr;
    lsu_wdata  = v.wdata;
    mem_ack    = 1'b0;
    mem_rdata  = 32'hA5A5_5A5A;
    #1 chk({t, " stall_accept"}, lsu_stall, 1);
    @(negedge clk);
    if (v.mis) begin
      chk({t, " mis_done"}, lsu_done, 1);
      chk({t, " mis_flag"}, lsu_misalign, 1);
      chk({t, " mis_rdata"}, lsu_rdata, 0);
      chk({t, " mis_noreq"}, mem_req, 0);
      chk({t, " mis_stall"}, lsu_stall, 0);
      lsu_valid = 1'b0;
    end else begin
      for (int c = 0; c <= int'(v.delay); c++) begin
        if (c > 0) @(negedge clk);
        chk({t, " req"}, mem_req, 1);
        chk({t, " maddr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
        chk({t, " be"}, {28'd0, mem_be}, {28'd0, v.be});
        chk({t, " mwe"}, mem_we, v.we);
        chk({t, " stall_busy"}, lsu_stall, 1);
        chk({t, " nodone_busy"}, lsu_done, 0);
        if (v.we) chk({t, " mwdata"}, mem_wdata, v.exp_wdata);
        // Disturb the inputs: the held request must not follow them.
        lsu_addr   = ~v.addr;
        lsu_wdata  = ~v.wdata;
        lsu_funct3 = v.f3 ^ 3'b011;
        lsu_we     = ~v.we;
        if (c == int'(v.delay)) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      chk({t, " done"}, lsu_done, 1);
      chk({t, " misflag"}, lsu_misalign, 0);
      chk({t, " rdata"}, lsu_rdata, v.exp_rdata);
      chk({t, " stall_resp"}, lsu_stall, 0);
      chk({t, " noreq_resp"}, mem_req, 0);
      lsu_valid = 1'b0;
    end
    @(negedge clk);
    chk({t, " done_once"}, lsu_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            we    f3      addr          wdata         rdata         dly   be       exp_wdata     exp_rdata     mis
    vt[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 4'd0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0};
    vt[1]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h1234_5678, 4'd0, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0};
    vt[2]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        4'd0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vt[3]  = '{1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h9ABC_0000, 4'd4, 4'b1100, 32'h0,        32'h0000_9ABC, 1'b0};
    vt[4]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h9ABC_0000, 4'd0, 4'b1100, 32'h0,        32'hFFFF_9ABC, 1'b0};
    vt[5]  = '{1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_8000, 4'd1, 4'b0010, 32'h0,        32'h0000_0080, 1'b0};
    vt[6]  = '{1'b0, 3'b000, 32'h0000_0002, 32'h0,        32'h007F_0000, 4'd0, 4'b0100, 32'h0,        32'h0000_007F, 1'b0};
    vt[7]  = '{1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h1234_8765, 4'd0, 4'b0011, 32'h0,        32'hFFFF_8765, 1'b0};
    vt[8]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 4'd2, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0};
    vt[9]  = '{1'b0, 3'b011, 32'h0000_0020, 32'h0,        32'hCAFE_F00D, 4'd0, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0};
    vt[10] = '{1'b0, 3'b110, 32'h0000_0004, 32'h0,        32'h8000_0001, 4'd0, 4'b1111, 32'h0,        32'h8000_0001, 1'b0};
    vt[11] = '{1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'hFFFF_FFFF, 4'd0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0};
    vt[12] = '{1'b1, 3'b010, 32'h0000_0400, 32'h1122_3344, 32'hFFFF_FFFF, 4'd3, 4'b1111, 32'h1122_3344, 32'h0,        1'b0};
    vt[13] = '{1'b1, 3'b101, 32'h0000_0000, 32'h0000_CDEF, 32'h0,        4'd0, 4'b0011, 32'hCDEF_CDEF, 32'h0,        1'b0};
    vt[14] = '{1'b1, 3'b100, 32'h0000_0003, 32'h0000_0077, 32'h0,        4'd0, 4'b1000, 32'h7777_7777, 32'h0,        1'b0};
    vt[15] = '{1'b0, 3'b001, 32'h0000_0005, 32'h0,        32'h0,        4'd0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vt[16] = '{1'b1, 3'b010, 32'h0000_0002, 32'h1111_1111, 32'h0,        4'd0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vt[17] = '{1'b0, 3'b101, 32'h0000_0003, 32'h0,        32'h0,        4'd0, 4'b0000, 32'h0,        32'h0,        1'b1};

    rst        = 1'b1;
    lsu_valid  = 1'b0;
    lsu_we     = 1'b0;
    lsu_funct3 = 3'b000;
    lsu_addr   = 32'h0;
    lsu_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;

    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_done", lsu_done, 0);
    chk("rst_stall", lsu_stall, 0);
    chk("rst_be", {28'd0, mem_be}, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_rdata", lsu_rdata, 0);
    chk("rst_mis", lsu_misalign, 0);
    rst = 1'b0;

    // Ack while idle must not start or complete anything.
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_done", lsu_done, 0);
    mem_ack = 1'b0;

    for (int i = 0; i < NV; i++) do_access(vt[i], i);

    // Reset in the middle of a store's BUSY phase.
    @(negedge clk);
    lsu_valid  = 1'b1;
    lsu_we     = 1'b1;
    lsu_funct3 = 3'b010;
    lsu_addr   = 32'h0000_0500;
    lsu_wdata  = 32'hAABB_CCDD;
    @(negedge clk);
    chk("abort_req_before", mem_req, 1);
    chk("abort_be_before", {28'd0, mem_be}, 32'h0000_000F);
    #2 rst = 1'b1;
    #1;
    chk("abort_req_async", mem_req, 0);
    chk("abort_maddr", mem_addr, 0);
    chk("abort_be", {28'd0, mem_be}, 0);
    chk("abort_mwdata", mem_wdata, 0);
    chk("abort_done", lsu_done, 0);
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("abort_done_hold", lsu_done, 0);
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_late_ack_done", lsu_done, 0);
      chk("abort_late_ack_req", mem_req, 0);
    end
    mem_ack = 1'b0;

    // SB followed by LBU with lsu_valid held across the boundary.
    @(negedge clk);
    lsu_valid  = 1'b1;
    lsu_we     = 1'b1;
    lsu_funct3 = 3'b000;
    lsu_addr   = 32'h0000_0005;
    lsu_wdata  = 32'h0000_005A;
    @(negedge clk);
    chk("b2b_sb_req", mem_req, 1);
    chk("b2b_sb_be", {28'd0, mem_be}, 32'h0000_0002);
    chk("b2b_sb_wdata", mem_wdata, 32'h5A5A_5A5A);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b_sb_done", lsu_done, 1);
    chk("b2b_sb_rdata", lsu_rdata, 0);
    chk("b2b_resp_stall", lsu_stall, 0);
    lsu_we     = 1'b0;
    lsu_funct3 = 3'b100;
    lsu_addr   = 32'h0000_0006;
    @(negedge clk);
    chk("b2b_gap_done", lsu_done, 0);
    chk("b2b_gap_req", mem_req, 0);
    chk("b2b_gap_stall", lsu_stall, 1);
    @(negedge clk);
    chk("b2b_lbu_req", mem_req, 1);
    chk("b2b_lbu_we", mem_we, 0);
    chk("b2b_lbu_be", {28'd0, mem_be}, 32'h0000_0004);
    chk("b2b_lbu_maddr", mem_addr, 32'h0000_0004);
    mem_ack   = 1'b1;
    mem_rdata = 32'h00C3_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b_lbu_done", lsu_done, 1);
    chk("b2b_lbu_rdata", lsu_rdata, 32'h0000_00C3);
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("b2b_lbu_done_once", lsu_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 lsu_valid  in  1  execute stage presents a load/store; held high until lsu_done.
REQ-004 lsu_we  in  1  1 = store, 0 = load; sampled with lsu_valid.
REQ-005 lsu_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 lsu_addr  in  `datawidth  byte address, taken from the ALU result.
REQ-007 lsu_wdata  in  `datawidth  store data (rs2).
REQ-008 lsu_stall  out  1  hold PC/pipeline.
REQ-009 lsu_done  out  1  one-cycle completion pulse.
REQ-010 lsu_rdata  out  `datawidth  extended load result, valid while lsu_done=1.
REQ-011 lsu_misalign  out  1  one-cycle pulse, coincident with lsu_done, on misaligned access.
REQ-012 mem_req, mem_we  out  1 each  memory request and write strobe.
REQ-013 mem_addr  out  `datawidth  word address, bits [1:0] forced to 00.
REQ-014 mem_be  out  4  byte enables; mem_wdata  out  `datawidth  lane-positioned store data.
REQ-015 mem_ack  in  1  memory completes the held request; mem_rdata  in  `datawidth  read word, valid with mem_ack.

Function
REQ-016 FSM states: IDLE, BUSY, RESP.
REQ-017 IDLE, lsu_valid=1, aligned -> latch addr/funct3/we/wdata, go BUSY.
REQ-018 IDLE, lsu_valid=1, misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) -> go RESP with misalign flag set; no memory request.
REQ-019 BUSY: mem_req=1 with stable mem_addr/mem_we/mem_be/mem_wdata until mem_ack; on mem_ack, register the formatted load data and go RESP.
REQ-020 RESP: lsu_done=1 for exactly one cycle, lsu_misalign=flag, lsu_stall=0; next state is IDLE unconditionally, and lsu_valid is ignored in RESP.
REQ-021 lsu_stall = (IDLE & lsu_valid) | BUSY, combinational.
REQ-022 Minimum latency: accept cycle, one BUSY cycle (same-cycle ack), one RESP cycle, so 3 cycles per access.
REQ-023 Byte lanes, little-endian: B -> be=0001<<addr[1:0], data byte replicated x4; H -> be=0011<<{addr[1],0}, halfword replicated x2; W -> be=1111; loads drive the same be.
REQ-024 Load extraction: select byte/halfword at addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-025 Unlisted funct3 (011, 110, 111) shall be treated as W; for stores funct3[2] is ignored.
REQ-026 lsu_rdata shall be 0 on stores and on misaligned completions.
REQ-027 mem_ack in IDLE or RESP shall be ignored.
REQ-028 Inputs shall be sampled only at acceptance; later changes while BUSY do not affect the request.

Reset
REQ-029 rst=1 forces state IDLE immediately, independent of clk.
REQ-030 On reset, all registered outputs and latched fields are cleared to 0, and mem_req drops immediately, including mid-BUSY.
REQ-031 An aborted access produces no lsu_done.

Structure
REQ-032 `datawidth, the funct3 load/store codes and the FSM state encoding shall live in the shared defines header.
REQ-033 One combinational sub-module, lsu_format, shall implement byte-enable and store-lane generation and load extract/extend; lsu holds the FSM and registers.

Verification
REQ-034 LB, addr=0x1003, mem_rdata=0x80FF_1234, ack in first BUSY cycle -> mem_addr=0x1000, be=1000, lsu_rdata=0xFFFF_FF80, done on the 3rd cycle.
REQ-035 SH, addr=0x2002, wdata=0x0000_BEEF -> mem_we=1, be=1100, mem_wdata=0xBEEF_BEEF, lsu_rdata=0.
REQ-036 LW, addr=0x0006 -> no mem_req, lsu_done=lsu_misalign=1 one cycle after acceptance, lsu_rdata=0.
REQ-037 LHU, addr=0x0002, ack delayed 4 cycles, mem_rdata=0x9ABC_0000 -> request fields stable and lsu_stall=1 throughout, lsu_rdata=0x0000_9ABC.
REQ-038 rst pulsed during BUSY of an SW -> mem_req low asynchronously, state IDLE, no lsu_done; a later ack is ignored.
REQ-039 Back-to-back SB then LBU with lsu_valid held -> second access accepted in the cycle after RESP, one done pulse each.
